// File: rtl/w5300_dbg_pkg.sv
// Shared constants for the W5300 debug error monitor: error bit indices,
// watchdog state encoding and the error-count ceiling.
package w5300_dbg_pkg;

    localparam int ERR_TIMEOUT   = 0;
    localparam int ERR_MISMATCH  = 1;
    localparam int ERR_INT_STUCK = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wd_state_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Add 0..3 events to the count, clamping at ERR_CNT_MAX.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0, n};
        return (sum > {1'b0, ERR_CNT_MAX}) ? ERR_CNT_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous debug pin; reset value is
// chosen per pin so an idle level reads back during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/w5300_err_monitor.sv
// W5300 debug error monitor: bus-handshake watchdog, readback mismatch check and
// stuck-INTn detector feeding three sticky active-low flags and a saturating count.
module w5300_err_monitor
    import w5300_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYC   = 1000,
    parameter int INT_STUCK_CYC = 5000000,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              ack,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              int_n_pin,
    input  logic              clr,
    output logic [2:0]        err_n,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam int ST_W = $clog2(INT_STUCK_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(INT_STUCK_CYC - 1);
    localparam logic [ST_W-1:0] ST_ARM  = ST_W'(INT_STUCK_CYC - 2);

    wd_state_e       state_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            busy_q;
    logic [ST_W-1:0] st_cnt_q, st_cnt_d;
    logic [2:0]      err_n_q, err_n_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            int_n_s;
    logic            evt_to, evt_mm, evt_st;
    logic [1:0]      n_evt;

    sync_2ff #(.RST_VAL(1'b1)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (int_n_pin),
        .q   (int_n_s)
    );

    // An ack on the expiry cycle completes the access, so it masks the timeout.
    assign evt_to = (state_q == WAIT) && !ack && (wd_cnt_q == WD_LAST);
    assign evt_mm = chk_en && (rd_data != exp_data);
    // Fire on the step into ST_LAST; the counter then parks there, giving one event per low period.
    assign evt_st = !int_n_s && (st_cnt_q == ST_ARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wd_cnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q  <= WAIT;
                        wd_cnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ack || (wd_cnt_q == WD_LAST)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        st_cnt_d = st_cnt_q;
        if (int_n_s)
            st_cnt_d = '0;
        else if (st_cnt_q != ST_LAST)
            st_cnt_d = st_cnt_q + 1'b1;

        n_evt     = {1'b0, evt_to} + {1'b0, evt_mm} + {1'b0, evt_st};
        err_n_d   = clr ? 3'b111 : err_n_q;
        err_cnt_d = sat_add(clr ? 8'd0 : err_cnt_q, n_evt);
        if (evt_to) err_n_d[ERR_TIMEOUT]   = 1'b0;
        if (evt_mm) err_n_d[ERR_MISMATCH]  = 1'b0;
        if (evt_st) err_n_d[ERR_INT_STUCK] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_cnt_q  <= '0;
            err_n_q   <= 3'b111;
            err_cnt_q <= '0;
        end else begin
            st_cnt_q  <= st_cnt_d;
            err_n_q   <= err_n_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_n   = err_n_q;
    assign err_cnt = err_cnt_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_w5300_err_monitor.sv
// Directed bench for w5300_err_monitor: a vector table for single-cycle behaviour
// plus hand sequences for timeout, stuck INTn, clr coincidence, saturation and reset.
module tb_w5300_err_monitor;

    localparam int TO  = 16;
    localparam int STK = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, ack, chk_en, clr, int_n_pin;
    logic [15:0] rd_data, exp_data;
    logic [2:0]  err_n;
    logic [7:0]  err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    w5300_err_monitor #(.TIMEOUT_CYC(TO), .INT_STUCK_CYC(STK), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .chk_en    (chk_en),
        .rd_data   (rd_data),
        .exp_data  (exp_data),
        .int_n_pin (int_n_pin),
        .clr       (clr),
        .err_n     (err_n),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        req, ack, chk_en, clr;
        logic [15:0] rd, exp;
        logic [2:0]  e_err_n;
        logic [7:0]  e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_in();
        req = 0; ack = 0; chk_en = 0; clr = 0; rd_data = 16'h0; exp_data = 16'h0;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic r, a, c, cl, input logic [15:0] rd, ex,
                        input logic [2:0] en, input logic [7:0] cn, input logic b);
        vec_t v;
        v.req = r; v.ack = a; v.chk_en = c; v.clr = cl; v.rd = rd; v.exp = ex;
        v.e_err_n = en; v.e_cnt = cn; v.e_busy = b;
        vq.push_back(v);
    endtask

    task automatic chk_all(input string name, input logic [2:0] en, input logic [7:0] cn, input logic b);
        chk({name, ".err_n"}, int'(err_n), int'(en));
        chk({name, ".err_cnt"}, int'(err_cnt), int'(cn));
        chk({name, ".busy"}, int'(busy), int'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        bit seen;
        rst = 1; int_n_pin = 1; idle_in();

        //        req ack chk clr rd        exp       err_n   cnt  busy
        addv(0, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 0);
        addv(1, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(0, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(0, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(0, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(0, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(0, 1, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 0);
        addv(1, 1, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(0, 1, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 0);
        addv(0, 0, 1, 0, 16'h1234, 16'h1235, 3'b101, 8'd1, 0);
        addv(0, 0, 1, 0, 16'hBEEF, 16'hBEEF, 3'b101, 8'd1, 0);
        addv(0, 0, 1, 0, 16'h8000, 16'h0000, 3'b101, 8'd2, 0);
        addv(0, 0, 0, 1, 16'h0,    16'h0,    3'b111, 8'd0, 0);
        addv(0, 0, 1, 1, 16'h0001, 16'h0002, 3'b101, 8'd1, 0);
        addv(0, 0, 0, 1, 16'h0,    16'h0,    3'b111, 8'd0, 0);
        addv(1, 0, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 1);
        addv(1, 0, 1, 0, 16'h5555, 16'h5555, 3'b111, 8'd0, 1);
        addv(0, 1, 0, 0, 16'h0,    16'h0,    3'b111, 8'd0, 0);

        #25;
        chk_all("reset", 3'b111, 8'd0, 0);
        @(negedge clk);
        rst = 0;
        step();

        foreach (vq[i]) begin
            req = vq[i].req; ack = vq[i].ack; chk_en = vq[i].chk_en; clr = vq[i].clr;
            rd_data = vq[i].rd; exp_data = vq[i].exp;
            step();
            chk_all($sformatf("vec%0d", i), vq[i].e_err_n, vq[i].e_cnt, vq[i].e_busy);
        end
        idle_in();

        // Timeout: 16 WAIT cycles with no ack; busy still set after the 15th.
        req = 1; step(); req = 0;
        for (int i = 0; i < TO - 1; i++) step();
        chk("to_pre.busy", int'(busy), 1);
        chk("to_pre.err_n", int'(err_n), 3'b111);
        step();
        chk_all("timeout", 3'b110, 8'd1, 0);
        clr = 1; step(); clr = 0;
        chk_all("to_clr", 3'b111, 8'd0, 0);

        // Ack on the expiry cycle wins.
        req = 1; step(); req = 0;
        for (int i = 0; i < TO - 1; i++) step();
        ack = 1; step(); ack = 0;
        chk_all("ack_expiry", 3'b111, 8'd0, 0);

        // Stuck INTn: 2 sync flops then 31 counting edges before the flag lands.
        int_n_pin = 0; seen = 0; n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!seen && !err_n[2]) begin seen = 1; n = i; end
        end
        chk("stuck.seen", int'(seen), 1);
        chk("stuck.latency", n, 33);
        chk_all("stuck.once", 3'b011, 8'd1, 0);
        int_n_pin = 1;
        for (int i = 0; i < 4; i++) step();
        clr = 1; step(); clr = 0;
        chk_all("stuck_clr", 3'b111, 8'd0, 0);

        // Two 20-cycle pulses separated by high time: count must restart each time.
        for (int p = 0; p < 2; p++) begin
            int_n_pin = 0;
            for (int i = 0; i < 20; i++) step();
            int_n_pin = 1;
            for (int i = 0; i < 6; i++) step();
        end
        chk_all("short_pulse", 3'b111, 8'd0, 0);

        // Timeout + mismatch + clr together after a prior error: set wins.
        chk_en = 1; rd_data = 16'h1; exp_data = 16'h2; step(); idle_in();
        chk_all("pre_coinc", 3'b101, 8'd1, 0);
        req = 1; step(); req = 0;
        for (int i = 0; i < TO - 1; i++) step();
        chk_en = 1; rd_data = 16'hAAAA; exp_data = 16'hAAAB; clr = 1;
        step(); idle_in();
        chk_all("coinc", 3'b100, 8'd2, 0);
        clr = 1; step(); clr = 0;
        chk_all("lone_clr", 3'b111, 8'd0, 0);

        // Saturation.
        chk_en = 1; rd_data = 16'h00FF; exp_data = 16'h0F0F;
        for (int i = 0; i < 254; i++) step();
        chk("sat254", int'(err_cnt), 254);
        step();
        chk("sat255", int'(err_cnt), 255);
        for (int i = 0; i < 45; i++) step();
        chk("sat300", int'(err_cnt), 255);
        chk("sat.err_n", int'(err_n), 3'b101);
        idle_in();

        // Asynchronous reset in the middle of WAIT.
        req = 1; step(); req = 0;
        step(); step();
        chk("mid.busy", int'(busy), 1);
        #3 rst = 1; #1;
        chk_all("async_rst", 3'b111, 8'd0, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < TO + 2; i++) step();
        chk_all("post_rst", 3'b111, 8'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
